// File: rtl/collenda_gpu_pkg.sv
// Shared GPU definitions: instruction word layout and default FIFO sizing.
package collenda_gpu_pkg;

    localparam int GPU_DATA_W      = 32;
    localparam int INSTR_W         = 2 * GPU_DATA_W;
    localparam int FIFO_DEPTH_LOG2 = 4;

    typedef struct packed {
        logic [GPU_DATA_W-1:0] a;
        logic [GPU_DATA_W-1:0] b;
    } instr_t;

endpackage

// File: rtl/collenda_fifo_ram.sv
// Instruction storage array: synchronous write, asynchronous read, no reset on contents.
module collenda_fifo_ram #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 64
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/collenda_instr_fifo.sv
// CPU-to-GPU instruction FIFO: wrreg edge detect, first-word-fall-through head, sticky overflow.
module collenda_instr_fifo
    import collenda_gpu_pkg::*;
#(
    parameter int DATA_W     = GPU_DATA_W,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     data_a,
    input  logic [DATA_W-1:0]     data_b,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_W-1:0]     instr_a,
    output logic [DATA_W-1:0]     instr_b,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic                  wr_prev_q, wr_prev_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic                  push, pop, push_acc;
    logic [2*DATA_W-1:0]   rdata;

    assign fifo_full   = (count_q == DEPTH_CNT);
    assign fifo_empty  = (count_q == '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign instr_valid = ~fifo_empty;
    assign instr_a     = rdata[2*DATA_W-1:DATA_W];
    assign instr_b     = rdata[DATA_W-1:0];

    // A pop frees the slot the write needs, so a full FIFO still accepts a push alongside a pop.
    assign push     = wr_en & ~wr_prev_q;
    assign pop      = instr_valid & instr_ready;
    assign push_acc = push & (~fifo_full | pop);

    always_comb begin
        wr_prev_d  = wr_en;
        wr_ptr_d   = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Clear wins over a drop reported in the same cycle.
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end else if (push & fifo_full & ~pop) begin
            overflow_d = 1'b1;
        end
    end

    // wr_prev resets high so a strobe already asserted during reset is not taken as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_prev_q  <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_prev_q  <= wr_prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    collenda_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .WIDTH  (2*DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i ({data_a, data_b}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_collenda_instr_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_collenda_instr_fifo;
    import collenda_gpu_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] data_a, data_b;
    logic          instr_valid, instr_ready;
    logic [DW-1:0] instr_a, instr_b;
    logic          fifo_full, fifo_empty;
    logic [4:0]    count;
    logic          overflow, ovf_clr;

    int checks = 0;
    int errors = 0;

    instr_t mq[$];
    logic   m_ovf;
    logic   m_wrprev;

    collenda_instr_fifo #(.DATA_W(DW), .DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .data_a      (data_a),
        .data_b      (data_b),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_a     (instr_a),
        .instr_b     (instr_b),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a plain queue of instructions, updated from the inputs seen at the edge.
    task automatic modelEdge();
        bit     push, pop, full;
        instr_t w;
        if (reset) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_wrprev = 1'b1;
        end else begin
            full = (mq.size() == DEPTH);
            push = wr_en && !m_wrprev;
            pop  = (mq.size() != 0) && instr_ready;
            w.a  = data_a;
            w.b  = data_b;
            if (pop) void'(mq.pop_front());
            if (push && (!full || pop)) mq.push_back(w);
            if (ovf_clr) m_ovf = 1'b0;
            else if (push && full && !pop) m_ovf = 1'b1;
            m_wrprev = wr_en;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_valid"}, 64'(instr_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            checkOutput({tag, "_a"}, 64'(instr_a), 64'(mq[0].a));
            checkOutput({tag, "_b"}, 64'(instr_b), 64'(mq[0].b));
        end
        checkOutput({tag, "_count"}, 64'(count), 64'(mq.size()));
        checkOutput({tag, "_full"}, 64'(fifo_full), 64'(mq.size() == DEPTH));
        checkOutput({tag, "_empty"}, 64'(fifo_empty), 64'(mq.size() == 0));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic wr,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic rdy, input logic clr);
        reset       = rst;
        wr_en       = wr;
        data_a      = a;
        data_b      = b;
        instr_ready = rdy;
        ovf_clr     = clr;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic writeEdge(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic rdy);
        applyStimulus(tag, 1'b0, 1'b1, a, b, rdy, 1'b0);
        applyStimulus(tag, 1'b0, 1'b0, a, b, 1'b0, 1'b0);
    endtask

    initial begin
        m_ovf    = 1'b0;
        m_wrprev = 1'b1;
        reset = 1'b1; wr_en = 1'b1; data_a = '0; data_b = '0; instr_ready = 1'b0; ovf_clr = 1'b0;
        #2;

        // 1: strobe held high through and after reset must not write
        applyStimulus("t1_rst", 1'b1, 1'b1, 32'h5, 32'h5, 1'b0, 1'b0);
        applyStimulus("t1_rst", 1'b1, 1'b1, 32'h5, 32'h5, 1'b0, 1'b0);
        applyStimulus("t1_hold", 1'b0, 1'b1, 32'h6, 32'h6, 1'b0, 1'b0);
        applyStimulus("t1_hold", 1'b0, 1'b1, 32'h6, 32'h6, 1'b0, 1'b0);
        checkOutput("t1_count0", 64'(count), 64'd0);
        checkOutput("t1_empty1", 64'(fifo_empty), 64'd1);
        applyStimulus("t1_low", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 2: single write becomes visible after one edge
        applyStimulus("t2_wr", 1'b0, 1'b1, 32'h1, 32'hAAAA, 1'b0, 1'b0);
        checkOutput("t2_a", 64'(instr_a), 64'h1);
        checkOutput("t2_b", 64'(instr_b), 64'hAAAA);
        checkOutput("t2_count", 64'(count), 64'd1);
        applyStimulus("t2_low", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 3: fill from empty, then a 17th edge is dropped
        applyStimulus("t3_rst", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus("t3_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) writeEdge("t3_fill", 32'h100 + i, 32'h200 + i, 1'b0);
        checkOutput("t3_count16", 64'(count), 64'd16);
        checkOutput("t3_full", 64'(fifo_full), 64'd1);
        writeEdge("t3_drop", 32'hDEAD, 32'hBEEF, 1'b0);
        checkOutput("t3_ovf", 64'(overflow), 64'd1);
        checkOutput("t3_head", 64'(instr_a), 64'h100);

        // 4: push and pop together while full, then drain in order
        applyStimulus("t4_pp", 1'b0, 1'b1, 32'h77, 32'h88, 1'b1, 1'b0);
        checkOutput("t4_count16", 64'(count), 64'd16);
        for (int i = 0; i < DEPTH - 1; i++)
            applyStimulus("t4_drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("t4_last", 64'(instr_a), 64'h77);
        applyStimulus("t4_drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("t4_empty", 64'(fifo_empty), 64'd1);

        // 5: twenty writes interleaved with pops so the write pointer wraps
        applyStimulus("t5_clr", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("t5_wr", 1'b0, 1'b1, 32'h500 + i, $urandom, 1'b0, 1'b0);
            applyStimulus("t5_rd", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        checkOutput("t5_empty", 64'(fifo_empty), 64'd1);

        // 6: reset with entries queued, then clear racing a new overflow
        for (int i = 0; i < 5; i++) writeEdge("t6_fill", $urandom, $urandom, 1'b0);
        checkOutput("t6_count5", 64'(count), 64'd5);
        applyStimulus("t6_rst", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("t6_count0", 64'(count), 64'd0);
        checkOutput("t6_valid0", 64'(instr_valid), 64'd0);
        applyStimulus("t6_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) writeEdge("t6_full", $urandom, $urandom, 1'b0);
        applyStimulus("t6_race", 1'b0, 1'b1, 32'h9, 32'h9, 1'b0, 1'b1);
        checkOutput("t6_ovf0", 64'(overflow), 64'd0);
        applyStimulus("t6_low", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            applyStimulus("rnd", ($urandom_range(0, 99) == 0), $urandom_range(0, 1),
                          $urandom, $urandom, ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
